// File: rtl/uart_demo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_demo_pkg
//  Purpose  : Shared constants and state encoding for the UART demo return
//             path (frame serializer and its hex-character helper).
//  Contents : ASCII character codes, default frame size, serializer states.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_demo_pkg;

    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;
    localparam logic [7:0] CHAR_0      = 8'h30;
    localparam logic [7:0] CHAR_A      = 8'h41;
    localparam int         FRAME_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_tx_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tx_serializer_if
//  Purpose  : Byte stream towards the UART TX engine (valid/ready handshake).
//  Signals  : tx_data  - byte offered by the master
//             tx_valid - tx_data is valid
//             tx_ready - slave accepts the byte this cycle
//  Modports : master (serializer side), slave (UART TX side)
//  Revision : 1.0 - initial release
// ============================================================================
interface frame_tx_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface
`default_nettype wire

// File: rtl/nib2ascii.sv
`default_nettype none
// ============================================================================
//  Module   : nib2ascii
//  Purpose  : Combinational nibble to uppercase ASCII hex character.
//  Ports    : i_nib  [3:0] - value 0..15
//             o_char [7:0] - '0'..'9' or 'A'..'F'
//  Revision : 1.0 - initial release
// ============================================================================
module nib2ascii
    import uart_demo_pkg::*;
(
    input  wire logic [3:0] i_nib,
    output logic      [7:0] o_char
);

    assign o_char = (i_nib < 4'd10) ? (CHAR_0 + {4'h0, i_nib})
                                    : (CHAR_A + {4'h0, i_nib} - 8'd10);

endmodule
`default_nettype wire

// File: rtl/frame_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tx_serializer
//  Purpose  : Captures one result frame and streams it byte by byte to the
//             UART TX engine, either as raw bytes or as uppercase hex text,
//             optionally terminated by CR LF.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             i_din         - result frame, sampled on the i_din_valid cycle
//             i_din_valid   - one-cycle frame strobe
//             o_busy        - capture until final byte accepted
//             o_overrun     - one-cycle pulse after a frame was dropped
//             o_done        - high on the cycle the final byte transfers
//             tx            - byte stream (master modport)
//  Revision : 1.0 - initial release
// ============================================================================
module frame_tx_serializer
    import uart_demo_pkg::*;
#(
    parameter int NBYTES      = FRAME_BYTES,
    parameter bit ASCII_HEX   = 1'b1,
    parameter bit APPEND_CRLF = 1'b1,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [8*NBYTES-1:0]   i_din,
    input  wire logic                  i_din_valid,
    output logic                       o_busy,
    output logic                       o_overrun,
    output logic                       o_done,
    frame_tx_serializer_if.master      tx
);

    localparam int              NCHAR  = ASCII_HEX ? 2 * NBYTES : NBYTES;
    localparam int              IDXW   = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam logic [IDXW-1:0] C_LAST = IDXW'(NCHAR - 1);

    ser_state_t            r_state;
    logic [8*NBYTES-1:0]   r_shadow;
    logic [IDXW-1:0]       r_idx;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_overrun;

    logic                  w_xfer;
    logic                  w_capture;
    logic                  w_last;
    logic [IDXW-1:0]       w_sel_idx;
    logic [IDXW-1:0]       w_pos;
    logic [8*NBYTES-1:0]   w_src;
    logic [7:0]            w_char;

    assign w_xfer    = r_tx_valid & tx.tx_ready;
    assign w_capture = (r_state == ST_IDLE) & i_din_valid;
    assign w_last    = (r_idx == C_LAST);

    // tx_data is registered, so the character loaded at each edge is the one
    // for the *next* index. On capture the frame is not yet in the shadow
    // register, so the first character is taken straight from i_din.
    assign w_sel_idx = w_capture ? '0 : r_idx + 1'b1;
    assign w_pos     = MSB_FIRST ? (C_LAST - w_sel_idx) : w_sel_idx;
    assign w_src     = w_capture ? i_din : r_shadow;

    generate
        if (ASCII_HEX) begin : g_hex
            logic [3:0] w_nib;
            assign w_nib = w_src[4*w_pos +: 4];
            nib2ascii u_nib2ascii (
                .i_nib  (w_nib),
                .o_char (w_char)
            );
        end else begin : g_raw
            assign w_char = w_src[8*w_pos +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // busy is still high on the done cycle, so a strobe there drops too
            r_overrun <= i_din_valid & r_busy;
            case (r_state)
                ST_IDLE: begin
                    if (i_din_valid) begin
                        r_shadow   <= i_din;
                        r_idx      <= '0;
                        r_tx_data  <= w_char;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (APPEND_CRLF) begin
                                r_tx_data <= CHAR_CR;
                                r_state   <= ST_CR;
                            end else begin
                                r_tx_valid <= 1'b0;
                                r_busy     <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_tx_data <= w_char;
                        end
                    end
                end
                ST_CR: begin
                    if (w_xfer) begin
                        r_tx_data <= CHAR_LF;
                        r_state   <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // done must coincide with the final transfer, which depends on tx_ready
    // in the same cycle, so it is decoded rather than registered.
    assign o_done = w_xfer & (APPEND_CRLF ? (r_state == ST_LF)
                                          : ((r_state == ST_SEND) & w_last));

    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_tx_serializer
//  Purpose  : Directed self-checking bench for frame_tx_serializer. Instance
//             A uses default parameters (hex, CR LF, MSB first); instance B
//             is raw, LSB first, no CR LF.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_tx_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_tx_serializer_if ifa ();
    frame_tx_serializer_if ifb ();

    logic [127:0] din_a, din_b;
    logic         dv_a, dv_b;
    logic         busy_a, ovr_a, done_a;
    logic         busy_b, ovr_b, done_b;

    frame_tx_serializer dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_din       (din_a),
        .i_din_valid (dv_a),
        .o_busy      (busy_a),
        .o_overrun   (ovr_a),
        .o_done      (done_a),
        .tx          (ifa.master)
    );

    frame_tx_serializer #(
        .NBYTES      (16),
        .ASCII_HEX   (1'b0),
        .APPEND_CRLF (1'b0),
        .MSB_FIRST   (1'b0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_din       (din_b),
        .i_din_valid (dv_b),
        .o_busy      (busy_b),
        .o_overrun   (ovr_b),
        .o_done      (done_b),
        .tx          (ifb.master)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         got_busy;
    int         got_done_at;

    // Expected character stream, written from the output format: hex chars
    // MSB nibble first plus CR LF, or raw bytes LSB first.
    function automatic void build_exp(input logic [127:0] d, input bit raw);
        logic [3:0] n;
        exp_q.delete();
        if (!raw) begin
            for (int i = 0; i < 32; i++) begin
                n = d[4*(31-i) +: 4];
                if (n <= 4'd9) exp_q.push_back(8'h30 + {4'h0, n});
                else           exp_q.push_back(8'h37 + {4'h0, n});
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            for (int i = 0; i < 16; i++) exp_q.push_back(d[8*i +: 8]);
        end
    endfunction

    // Strobe one frame; returns on the negedge where the first byte is offered.
    task automatic send(input bit sel_b, input logic [127:0] d);
        if (sel_b) begin din_b = d; dv_b = 1'b1; end
        else       begin din_a = d; dv_a = 1'b1; end
        @(negedge clk);
        if (sel_b) begin dv_b = 1'b0; din_b = ~d; end
        else       begin dv_a = 1'b0; din_a = ~d; end
    endtask

    // Drive tx_ready (pct% high) and record transfers until done or budget.
    task automatic collect(input bit sel_b, input int pct, input string tag);
        bit         fin = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        bit         r;
        logic       v, dn, b;
        logic [7:0] x;
        int         cyc = 0;
        got.delete();
        got_busy    = 0;
        got_done_at = -1;
        while (!fin && cyc < 3000) begin
            r = ($urandom_range(99) < pct);
            if (sel_b) ifb.tx_ready = r; else ifa.tx_ready = r;
            #1;
            v  = sel_b ? ifb.tx_valid : ifa.tx_valid;
            x  = sel_b ? ifb.tx_data  : ifa.tx_data;
            dn = sel_b ? done_b : done_a;
            b  = sel_b ? busy_b : busy_a;
            if (prev_stall) begin
                checks++;
                if (v !== 1'b1 || x !== prev_data) begin
                    errors++;
                    $display("FAIL %s_stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             tag, v, x, prev_data);
                end
            end
            prev_stall = (v === 1'b1) && !r;
            prev_data  = x;
            if (b === 1'b1) got_busy++;
            if (v === 1'b1 && r) begin
                got.push_back(x);
                if (dn === 1'b1) begin
                    got_done_at = got.size();
                    fin = 1'b1;
                end
            end else if (dn === 1'b1) begin
                got_done_at = -2;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles, required done", tag, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv_a = 1'b0; dv_b = 1'b0; din_a = '0; din_b = '0;
        ifa.tx_ready = 1'b0; ifb.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy_a, ovr_a, ifa.tx_valid, done_a, ifa.tx_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_a: busy=%b ovr=%b valid=%b done=%b data=%h, required all 0",
                     busy_a, ovr_a, ifa.tx_valid, done_a, ifa.tx_data);
        end
        checks++;
        if ({busy_b, ovr_b, ifb.tx_valid, done_b, ifb.tx_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_b: busy=%b ovr=%b valid=%b done=%b data=%h, required all 0",
                     busy_b, ovr_b, ifb.tx_valid, done_b, ifb.tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_pad();
        int bad = -1;
        send(1'b0, 128'h5);
        #1;
        checks++;
        if (ifa.tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL t1_latency: tx_valid=%b one cycle after strobe, required 1", ifa.tx_valid);
        end
        collect(1'b0, 100, "t1");
        for (int i = 0; i < 31; i++) exp_q.push_back(8'h30);
        exp_q.delete();
        for (int i = 0; i < 31; i++) exp_q.push_back(8'h30);
        exp_q.push_back(8'h35); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != 34) begin
            errors++;
            $display("FAIL t1_bytes: count=%0d first bad index=%0d, required 34 bytes 31x30,35,0D,0A",
                     got.size(), bad);
        end
        checks++;
        if (got_done_at != 34) begin
            errors++;
            $display("FAIL t1_done: done on byte %0d, required 34", got_done_at);
        end
        checks++;
        if (got_busy != 34) begin
            errors++;
            $display("FAIL t1_busy: busy cycles=%0d, required 34", got_busy);
        end
        #1;
        checks++;
        if (busy_a !== 1'b0 || ifa.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: busy=%b valid=%b after done, required 0 0", busy_a, ifa.tx_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        string s = "0123456789ABCDEFFEDCBA9876543210";
        int    bad = -1;
        send(1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210);
        collect(1'b0, 30, "t2");
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != 34) begin
            errors++;
            $display("FAIL t2_string: count=%0d first bad index=%0d got=%h, required %h",
                     got.size(), bad, (bad >= 0 && bad < got.size()) ? got[bad] : 8'h00,
                     (bad >= 0) ? exp_q[bad] : 8'h00);
        end
        checks++;
        if (got_done_at != 34) begin
            errors++;
            $display("FAIL t2_done: done on byte %0d, required 34", got_done_at);
        end
        ifa.tx_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_raw_lsb();
        int bad = -1;
        send(1'b1, 128'h0F0E0D0C0B0A0908_0706050403020100);
        collect(1'b1, 100, "t3");
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != 16) begin
            errors++;
            $display("FAIL t3_bytes: count=%0d first bad index=%0d, required 16 bytes 00..0F",
                     got.size(), bad);
        end
        checks++;
        if (got_done_at != 16) begin
            errors++;
            $display("FAIL t3_done: done on byte %0d, required 16", got_done_at);
        end
        #1;
        checks++;
        if (busy_b !== 1'b0 || ifb.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t3_idle: busy=%b valid=%b, required 0 0", busy_b, ifb.tx_valid);
        end
        ifb.tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int ovr_cnt = 0;
        int c = 0;
        bit fin = 1'b0;
        int bad = -1;
        ifa.tx_ready = 1'b1;
        send(1'b0, 128'h5);
        got.delete();
        while (!fin && c < 200) begin
            #1;
            if (ovr_a === 1'b1) ovr_cnt++;
            if (ifa.tx_valid === 1'b1) got.push_back(ifa.tx_data);
            if (done_a === 1'b1) fin = 1'b1;
            dv_a  = (c == 5) || fin;
            din_a = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
            @(negedge clk);
            c++;
        end
        #1;
        if (ovr_a === 1'b1) ovr_cnt++;
        checks++;
        if (ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL t4_ovr_done: overrun=%b after strobe on done cycle, required 1", ovr_a);
        end
        checks++;
        if (ovr_cnt != 2) begin
            errors++;
            $display("FAIL t4_ovr_count: overrun pulses=%0d, required 2", ovr_cnt);
        end
        build_exp(128'h5, 1'b0);
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != 34) begin
            errors++;
            $display("FAIL t4_unchanged: count=%0d first bad index=%0d, required original 34 bytes",
                     got.size(), bad);
        end
        dv_a  = 1'b1;
        din_a = 128'hF;
        @(negedge clk);
        dv_a  = 1'b0;
        din_a = '0;
        #1;
        checks++;
        if (ifa.tx_valid !== 1'b1 || ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL t4_accept: valid=%b ovr=%b, required valid=1 ovr=0", ifa.tx_valid, ovr_a);
        end
        collect(1'b0, 100, "t4");
        build_exp(128'hF, 1'b0);
        checks++;
        if (got.size() != 34 || got[31] !== 8'h46 || got[30] !== 8'h30) begin
            errors++;
            $display("FAIL t4_second: count=%0d byte31=%h, required 34 bytes ending 46 0D 0A",
                     got.size(), got[31]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad = -1;
        ifa.tx_ready = 1'b1;
        send(1'b0, 128'h1111);
        repeat (9) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifa.tx_valid, busy_a, done_a, ifa.tx_data} !== 11'h000) begin
            errors++;
            $display("FAIL t5_async: valid=%b busy=%b done=%b data=%h, required all 0",
                     ifa.tx_valid, busy_a, done_a, ifa.tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ifa.tx_valid !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL t5_no_resume: valid=%b busy=%b, required 0 0", ifa.tx_valid, busy_a);
        end
        @(negedge clk);
        send(1'b0, 128'hCAFE_0000_0000_0000_0000_0000_0000_BABE);
        collect(1'b0, 100, "t5");
        build_exp(128'hCAFE_0000_0000_0000_0000_0000_0000_BABE, 1'b0);
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != 34) begin
            errors++;
            $display("FAIL t5_after: count=%0d first bad index=%0d, required full 34-byte frame",
                     got.size(), bad);
        end
        @(negedge clk);
    endtask

    task automatic test_hex_bounds();
        ifa.tx_ready = 1'b1;
        send(1'b0, 128'h9AF);
        collect(1'b0, 100, "t6");
        checks++;
        if (got.size() != 34 || got[29] !== 8'h39 || got[30] !== 8'h41 || got[31] !== 8'h46) begin
            errors++;
            $display("FAIL t6_hex: count=%0d chars=%h %h %h, required 39 41 46",
                     got.size(), got[29], got[30], got[31]);
        end
        checks++;
        if (got[28] !== 8'h30 || got[32] !== 8'h0D || got[33] !== 8'h0A) begin
            errors++;
            $display("FAIL t6_frame: byte28=%h byte32=%h byte33=%h, required 30 0D 0A",
                     got[28], got[32], got[33]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_pad();
        test_stall();
        test_raw_lsb();
        test_overrun();
        test_reset_mid();
        test_hex_bounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
